// File: rtl/cam_pkg.sv
// Shared types and constants for the camera window front end.
// The optional test-pattern generator is built only when CAM_TEST_PATTERN_EN is defined.
package cam_pkg;

  localparam int DSIZE_DEF  = 8;
  localparam int HCNT_W_DEF = 12;
  localparam int VCNT_W_DEF = 11;
  localparam int SKIP_W_DEF = 4;
  localparam int FCNT_W_DEF = 16;

  // Value of the Cb and Cr bytes in the test pattern (neutral chroma).
  localparam logic [7:0] CAM_CHROMA = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SKIP   = 2'd2
  } cam_state_t;

endpackage

// File: rtl/cam_sync_cnt.sv
// Input register stage (c1), vsync/href edge detection, byte and line counters,
// and measurement of the real line length and frame height.
module cam_sync_cnt
  import cam_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int HCNT_W = HCNT_W_DEF,
  parameter int VCNT_W = VCNT_W_DEF
) (
  input  logic              cam_clk,
  input  logic              cam_rst,
  input  logic [DSIZE-1:0]  cam_data,
  input  logic              cam_href,
  input  logic              cam_vsync,
  output logic [DSIZE-1:0]  data_c1,
  output logic              href_c1,
  output logic              vs_re,
  output logic              href_fe,
  output logic [HCNT_W-1:0] byte_idx,
  output logic [VCNT_W-1:0] line_idx,
  output logic [HCNT_W-1:0] meas_bpl,
  output logic [VCNT_W-1:0] meas_lines
);

  logic vsync_c1;
  logic vsync_c2;
  logic href_c2;

  assign vs_re   = vsync_c1 & ~vsync_c2;
  assign href_fe = ~href_c1 & href_c2;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge cam_clk) begin
    if (cam_rst) begin
      data_c1    <= '0;
      href_c1    <= 1'b0;
      vsync_c1   <= 1'b0;
      href_c2    <= 1'b0;
      vsync_c2   <= 1'b0;
      byte_idx   <= '0;
      line_idx   <= '0;
      meas_bpl   <= '0;
      meas_lines <= '0;
    end else begin
      data_c1  <= cam_data;
      href_c1  <= cam_href;
      vsync_c1 <= cam_vsync;
      href_c2  <= href_c1;
      vsync_c2 <= vsync_c1;

      if (href_fe) begin
        meas_bpl <= byte_idx;
      end

      // Frame start wins over everything: a byte arriving in the vs_re cycle is not counted.
      if (vs_re) begin
        meas_lines <= line_idx;
        byte_idx   <= '0;
        line_idx   <= '0;
      end else if (href_fe) begin
        byte_idx <= '0;
        if (line_idx != '1) begin
          line_idx <= line_idx + VCNT_W'(1);
        end
      end else if (href_c1 && (byte_idx != '1)) begin
        byte_idx <= byte_idx + HCNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cam_window_if.sv
// Camera capture front end: crop window, frame decimation, frame error detection.
// Optional build macro CAM_TEST_PATTERN_EN adds a YUYV test-pattern source.
module cam_window_if
  import cam_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int HCNT_W = HCNT_W_DEF,
  parameter int VCNT_W = VCNT_W_DEF,
  parameter int SKIP_W = SKIP_W_DEF,
  parameter int FCNT_W = FCNT_W_DEF
) (
  input  logic              cam_clk,
  input  logic              cam_rst,
  input  logic [DSIZE-1:0]  cam_data,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic              en_cam,
  input  logic [HCNT_W-1:0] cfg_x0,
  input  logic [HCNT_W-1:0] cfg_w,
  input  logic [VCNT_W-1:0] cfg_y0,
  input  logic [VCNT_W-1:0] cfg_h,
  input  logic [SKIP_W-1:0] cfg_skip,
  input  logic              cfg_tp_en,
  output logic              cam_vld,
  output logic [DSIZE-1:0]  cam_rd_data,
  output logic              cam_sof,
  output logic              cam_eof,
  output logic              frm_err,
  output logic [FCNT_W-1:0] frm_cnt,
  output logic [HCNT_W-1:0] meas_bpl,
  output logic [VCNT_W-1:0] meas_lines
);

  logic [DSIZE-1:0]  data_c1;
  logic              href_c1;
  logic              vs_re;
  logic              href_fe;
  logic [HCNT_W-1:0] byte_idx;
  logic [VCNT_W-1:0] line_idx;

  cam_sync_cnt #(
    .DSIZE  (DSIZE),
    .HCNT_W (HCNT_W),
    .VCNT_W (VCNT_W)
  ) u_sync_cnt (
    .cam_clk    (cam_clk),
    .cam_rst    (cam_rst),
    .cam_data   (cam_data),
    .cam_href   (cam_href),
    .cam_vsync  (cam_vsync),
    .data_c1    (data_c1),
    .href_c1    (href_c1),
    .vs_re      (vs_re),
    .href_fe    (href_fe),
    .byte_idx   (byte_idx),
    .line_idx   (line_idx),
    .meas_bpl   (meas_bpl),
    .meas_lines (meas_lines)
  );

  logic en_meta;
  logic en_sync;

  // Per-frame shadow copy of the window; end values carry one extra bit so x0+w cannot wrap.
  logic [HCNT_W-1:0] x0_sh;
  logic [HCNT_W:0]   x_end_sh;
  logic [VCNT_W-1:0] y0_sh;
  logic [VCNT_W:0]   y_end_sh;
  logic              eof_seen;

  cam_state_t        state;
  cam_state_t        state_nxt;
  logic [SKIP_W-1:0] skip_cnt;
  logic [SKIP_W-1:0] skip_nxt;

  logic             in_x;
  logic             in_y;
  logic             in_win;
  logic             sof_nxt;
  logic             eof_nxt;
  logic             err_nxt;
  logic [DSIZE-1:0] pix;

  // NOTE: every signal written in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    if (vs_re) begin
      if (!en_sync) begin
        state_nxt = ST_IDLE;
      end else if ((skip_cnt == '0) && (cfg_w != '0) && (cfg_h != '0)) begin
        state_nxt = ST_ACTIVE;
        skip_nxt  = cfg_skip;
      end else begin
        state_nxt = ST_SKIP;
        if (skip_cnt != '0) begin
          skip_nxt = skip_cnt - SKIP_W'(1);
        end
      end
    end
  end

  always_comb begin
    in_x    = ({1'b0, byte_idx} >= {1'b0, x0_sh}) && ({1'b0, byte_idx} < x_end_sh);
    in_y    = ({1'b0, line_idx} >= {1'b0, y0_sh}) && ({1'b0, line_idx} < y_end_sh);
    in_win  = (state == ST_ACTIVE) && !vs_re && href_c1 && !eof_seen && in_x && in_y;
    sof_nxt = in_win && (byte_idx == x0_sh) && (line_idx == y0_sh);
    eof_nxt = in_win && ({1'b0, byte_idx} == x_end_sh - 1'b1)
                     && ({1'b0, line_idx} == y_end_sh - 1'b1);
    // A captured frame that reaches the next frame start without its eof is broken.
    err_nxt = vs_re && (state == ST_ACTIVE) && !eof_seen;
  end

`ifdef CAM_TEST_PATTERN_EN
  logic tp_sh;

  always_comb begin
    pix = data_c1;
    if (tp_sh) begin
      unique case (byte_idx[1:0])
        2'b01, 2'b11: pix = DSIZE'(CAM_CHROMA);
        default:      pix = DSIZE'(byte_idx[8:1]);
      endcase
    end
  end
`else
  logic unused_tp_en;

  assign unused_tp_en = cfg_tp_en;
  assign pix          = data_c1;
`endif

  always_ff @(posedge cam_clk) begin
    if (cam_rst) begin
      en_meta     <= 1'b0;
      en_sync     <= 1'b0;
      state       <= ST_IDLE;
      skip_cnt    <= '0;
      x0_sh       <= '0;
      x_end_sh    <= '0;
      y0_sh       <= '0;
      y_end_sh    <= '0;
      eof_seen    <= 1'b0;
      cam_vld     <= 1'b0;
      cam_rd_data <= '0;
      cam_sof     <= 1'b0;
      cam_eof     <= 1'b0;
      frm_err     <= 1'b0;
      frm_cnt     <= '0;
`ifdef CAM_TEST_PATTERN_EN
      tp_sh       <= 1'b0;
`endif
    end else begin
      en_meta  <= en_cam;
      en_sync  <= en_meta;
      state    <= state_nxt;
      skip_cnt <= skip_nxt;

      if (vs_re) begin
        x0_sh    <= cfg_x0;
        x_end_sh <= {1'b0, cfg_x0} + {1'b0, cfg_w};
        y0_sh    <= cfg_y0;
        y_end_sh <= {1'b0, cfg_y0} + {1'b0, cfg_h};
        eof_seen <= 1'b0;
`ifdef CAM_TEST_PATTERN_EN
        tp_sh    <= cfg_tp_en;
`endif
      end else if (eof_nxt) begin
        eof_seen <= 1'b1;
      end

      cam_vld     <= in_win;
      cam_rd_data <= in_win ? pix : '0;
      cam_sof     <= sof_nxt;
      cam_eof     <= eof_nxt;
      frm_err     <= err_nxt;
      if (eof_nxt) begin
        frm_cnt <= frm_cnt + FCNT_W'(1);
      end
    end
  end

endmodule
